// File: rtl/sha256_pkg.sv
// SHA-256 constants, round functions and shared types for the pipelined hashing datapath.
package sha256_pkg;

  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } state_t;

  // Index 0 holds the word consumed by the current round.
  typedef logic [15:0][31:0] window_t;

  localparam state_t H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic window_t load_window(input logic [511:0] blk);
    window_t w;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    return w;
  endfunction

  function automatic logic [255:0] add_h0(input state_t s);
    return {H0.a + s.a, H0.b + s.b, H0.c + s.c, H0.d + s.d,
            H0.e + s.e, H0.f + s.f, H0.g + s.g, H0.h + s.h};
  endfunction

  // An all-zero digest reports 256 so every 8-bit threshold is met.
  function automatic logic [8:0] lzc256(input logic [255:0] x);
    logic [8:0] n;
    n = 9'd256;
    for (int i = 0; i < 256; i++)
      if (x[i]) n = 9'(255 - i);
    return n;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus message-schedule window advance.
module sha256_round
  import sha256_pkg::*;
#(
  parameter int ROUND = 0
) (
  input  logic [255:0] st_in,
  input  logic [511:0] w_in,
  output logic [255:0] st_out,
  output logic [511:0] w_out
);

  state_t s, n;
  window_t w, wn;
  logic [31:0] t1, t2;

  assign s = st_in;
  assign w = w_in;

  always_comb begin
    t1 = s.h + bsig1(s.e) + ch(s.e, s.f, s.g) + K[ROUND] + w[0];
    t2 = bsig0(s.a) + maj(s.a, s.b, s.c);
    n  = s;
    n.h = s.g;
    n.g = s.f;
    n.f = s.e;
    n.e = s.d + t1;
    n.d = s.c;
    n.c = s.b;
    n.b = s.a;
    n.a = t1 + t2;
  end

  // The window runs 16 words ahead, so rounds 48+ need no new schedule words.
  if (ROUND < 48) begin : g_sched
    assign wn = {ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0], w[15:1]};
  end else begin : g_drain
    assign wn = {32'h0, w[15:1]};
  end

  assign st_out = n;
  assign w_out  = wn;

endmodule

// File: rtl/sha256_pipe_top.sv
// Fully pipelined SHA-256 over one padded block per cycle with a leading-zero difficulty check.
module sha256_pipe_top
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64,
  parameter int ZCNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [511:0]      d_i,
  input  logic [ZCNT_W-1:0] num_zero_i,
  output logic [255:0]      d_o,
  output logic              matched_o,
  output logic [511:0]      original_o
);

  logic [NUM_ROUNDS:0] vld_pipe;
  logic [511:0]        blk_q  [NUM_ROUNDS+1];
  logic [ZCNT_W-1:0]   nz_q   [NUM_ROUNDS+1];
  window_t             w_q    [NUM_ROUNDS];
  state_t              st_q   [1:NUM_ROUNDS];
  window_t             w_nxt  [NUM_ROUNDS];
  state_t              st_nxt [NUM_ROUNDS];

  logic [255:0] digest;
  logic [8:0]   lz;

  for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_round
    state_t st_in;
    if (r == 0) begin : g_first
      assign st_in = H0;
    end else begin : g_rest
      assign st_in = st_q[r];
    end
    sha256_round #(.ROUND(r)) u_round (
      .st_in  (st_in),
      .w_in   (w_q[r]),
      .st_out (st_nxt[r]),
      .w_out  (w_nxt[r])
    );
  end

  assign digest = add_h0(st_q[NUM_ROUNDS]);
  assign lz     = lzc256(digest);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int r = 0; r <= NUM_ROUNDS; r++) begin
        blk_q[r] <= '0;
        nz_q[r]  <= '0;
      end
      for (int r = 0; r < NUM_ROUNDS; r++) w_q[r] <= '0;
      for (int r = 1; r <= NUM_ROUNDS; r++) st_q[r] <= '0;
      d_o        <= '0;
      original_o <= '0;
      matched_o  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[NUM_ROUNDS-1:0], 1'b1};
      blk_q[0] <= d_i;
      nz_q[0]  <= num_zero_i;
      w_q[0]   <= load_window(d_i);
      for (int r = 1; r <= NUM_ROUNDS; r++) begin
        blk_q[r] <= blk_q[r-1];
        nz_q[r]  <= nz_q[r-1];
        st_q[r]  <= st_nxt[r-1];
      end
      for (int r = 1; r < NUM_ROUNDS; r++) w_q[r] <= w_nxt[r-1];
      // Bubbles load zeros so nothing leaks out before the first real block.
      d_o        <= vld_pipe[NUM_ROUNDS] ? digest : '0;
      original_o <= vld_pipe[NUM_ROUNDS] ? blk_q[NUM_ROUNDS] : '0;
      matched_o  <= vld_pipe[NUM_ROUNDS] && (32'(lz) >= 32'(nz_q[NUM_ROUNDS]));
    end
  end

endmodule

// File: tb/tb_sha256_pipe_top.sv
// Randomized and directed bench for sha256_pipe_top against a plain-arithmetic SHA-256 model.
module tb_sha256_pipe_top;

  localparam int LAT = 65;

  localparam logic [255:0] DIG_A   = 256'h559aead08264d5795d3909718cdd05abd49572e84fe55590eef31a88a08fdffd;
  localparam logic [255:0] DIG_B   = 256'hdf7e70e5021544f4834bbee64a9e3789febc4be81470df629cad6ddb03320a5c;
  localparam logic [255:0] DIG_M   = 256'h08f271887ce94707da822d5263bae19d5519cb3614e0daedc4c7ce5dab7473f1;
  localparam logic [255:0] DIG_Z   = 256'hbbeebd879e1dff6918546dc0c179fdde505f2a21591c9a9c96e36b054ec5af83;
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] d_i;
  logic [7:0]   num_zero_i;
  logic [255:0] d_o;
  logic         matched_o;
  logic [511:0] original_o;

  int checks = 0;
  int errors = 0;

  bit           cur_known;
  logic [255:0] cur_kdig;
  bit           cur_kmatch;

  typedef struct {
    logic [511:0] blk;
    logic [7:0]   nz;
    bit           known;
    logic [255:0] kdig;
    bit           kmatch;
  } ent_t;

  ent_t q[$];

  sha256_pipe_top dut (
    .clk        (clk),
    .reset      (reset),
    .d_i        (d_i),
    .num_zero_i (num_zero_i),
    .d_o        (d_o),
    .matched_o  (matched_o),
    .original_o (original_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_sha(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = IV[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = IV[i] + v[i];
    return res;
  endfunction

  function automatic int lead0(input logic [255:0] d);
    for (int i = 255; i >= 0; i--)
      if (d[i]) return 255 - i;
    return 256;
  endfunction

  function automatic logic [511:0] letter_blk(input logic [7:0] c);
    return {c, 8'h80, 432'd0, 64'd8};
  endfunction

  task automatic drive(input logic [511:0] b, input logic [7:0] nz,
                       input bit kn, input logic [255:0] kd, input bit km);
    @(negedge clk);
    d_i        = b;
    num_zero_i = nz;
    cur_known  = kn;
    cur_kdig   = kd;
    cur_kmatch = km;
  endtask

  task automatic drive_rand(input int n);
    logic [511:0] b;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = $urandom();
      drive(b, 8'($urandom_range(0, 6)), 1'b0, '0, 1'b0);
    end
  endtask

  always @(negedge reset) q.delete();

  // Scoreboard: whatever was sampled LAT edges ago must be on the outputs now.
  always @(posedge clk) begin
    ent_t e;
    logic [255:0] dig;
    bit m;
    if (reset) begin
      q.push_back('{d_i, num_zero_i, cur_known, cur_kdig, cur_kmatch});
      #1;
      if (reset) begin
        if (q.size() > LAT) begin
          e   = q.pop_front();
          dig = ref_sha(e.blk);
          m   = (lead0(dig) >= int'(e.nz));
          chk("digest", d_o, dig);
          chk("original", original_o, e.blk);
          chk("matched", matched_o, m);
          if (e.known) begin
            chk("known_digest", d_o, e.kdig);
            chk("known_matched", matched_o, e.kmatch);
          end
        end else begin
          chk("idle_d", d_o, '0);
          chk("idle_orig", original_o, '0);
          chk("idle_m", matched_o, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [511:0] abc;
    reset      = 1'b0;
    d_i        = '0;
    num_zero_i = '0;
    cur_known  = 1'b0;
    cur_kdig   = '0;
    cur_kmatch = 1'b0;
    #3;
    chk("rst_d", d_o, '0);
    chk("rst_orig", original_o, '0);
    chk("rst_m", matched_o, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int c = 0; c < 26; c++) begin
      case (c)
        0:       drive(letter_blk(8'h41), 8'd3, 1'b1, DIG_A, 1'b0);
        1:       drive(letter_blk(8'h42), 8'd3, 1'b1, DIG_B, 1'b0);
        12:      drive(letter_blk(8'h4d), 8'd3, 1'b1, DIG_M, 1'b1);
        25:      drive(letter_blk(8'h5a), 8'd3, 1'b1, DIG_Z, 1'b0);
        default: drive(letter_blk(8'(8'h41 + c)), 8'd3, 1'b0, '0, 1'b0);
      endcase
    end

    abc = {24'h616263, 8'h80, 416'd0, 64'd24};
    drive(abc, 8'd0, 1'b1, DIG_ABC, 1'b1);
    drive_rand(20);

    drive(letter_blk(8'h4d), 8'd0,   1'b1, DIG_M, 1'b1);
    drive(letter_blk(8'h4d), 8'd4,   1'b1, DIG_M, 1'b1);
    drive(letter_blk(8'h4d), 8'd5,   1'b1, DIG_M, 1'b0);
    drive(letter_blk(8'h4d), 8'd255, 1'b1, DIG_M, 1'b0);
    for (int k = 0; k < 6; k++)
      drive(letter_blk(8'h4d), (k % 2 == 0) ? 8'd4 : 8'd5, 1'b1, DIG_M, (k % 2 == 0));

    drive_rand(90);

    // Mid-cycle reset while blocks are in flight.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_d", d_o, '0);
    chk("async_rst_orig", original_o, '0);
    chk("async_rst_m", matched_o, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 72; k++) drive('0, 8'd0, 1'b0, '0, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_pipe_top.md
Name: sha256_pipe_top

Overview:
Fully pipelined, single-tile SHA-256 engine for one pre-padded 512-bit message block, accepting a new block every clock cycle. It computes the digest against the standard initial hash H0 and flags whether the digest has at least num_zero_i leading zero bits, a proof-of-work style difficulty check. The block also returns the plaintext block that produced each digest. It is the top of the hashing datapath; upstream logic supplies already-padded blocks.

Parameters:
- NUM_ROUNDS, 64, number of compression rounds; one pipeline stage per round. Fixed for SHA-256 and not meant to be overridden.
- ZCNT_W, 8, width of the leading-zero threshold input.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_i  in  512  padded message block; word W0 = d_i[511:480], through W15 = d_i[31:0].
- num_zero_i  in  8  required minimum count of leading zero bits in the digest.
- d_o  out  256  SHA-256 digest; H0 word in [255:224].
- matched_o  out  1  high when the digest has at least the threshold number of leading zero bits.
- original_o  out  512  the d_i block that produced the current d_o.

Behaviour:
- Reset (reset=0, asynchronous): clears every pipeline register, the per-stage valid bits, d_o, original_o and matched_o to 0. Outputs stay 0 until the first valid block emerges.
- Input stage S0:
  - Every rising edge with reset=1 captures d_i and num_zero_i and sets valid=1.
  - There is no stall or handshake. Throughput is one block per cycle, unconditionally.
- Round stages S1..S64:
  - Stage r carries the working variables a..h, a 16-word message-schedule window, the original block, the threshold and a valid bit.
  - Stage r performs FIPS 180-4 round r-1 with constant K[r-1] and word Wt.
  - For t ≥ 16: Wt = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16, computed in-stage and shifted into the window.
  - All additions are modulo 2^32.
  - S1 starts from a..h = H0 (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
- Output stage S65:
  - Registers d_o = {H0[i] + final var[i]} for i = a..h, each sum mod 2^32.
  - Registers original_o = the carried block.
  - Registers matched_o = valid AND (count of leading zero bits of the new digest, 0..256) ≥ carried num_zero_i.
- Latency: a block sampled at rising edge k appears on d_o, original_o and matched_o after rising edge k+65, i.e. it is visible in the cycle starting at edge k+65.
- Streaming: consecutive blocks emerge on consecutive cycles, in order, without interference between them.
- Invalid stages (bubbles after reset): output registers load 0 and matched_o = 0.
- Threshold boundaries:
  - num_zero_i = 0 gives matched_o = 1 for every valid block.
  - Thresholds 1..255 compare against the leading-zero count as an ordinary unsigned compare.
  - An all-zero digest counts as 256 leading zeros; any 8-bit threshold therefore matches it.
- Per-block threshold: num_zero_i is pipelined with its own block, so each block is judged against the threshold sampled with it.
- Reset mid-stream: flushes all in-flight blocks. They are never output.

Decomposition:
- Package sha256_pkg holds:
  - the K[0:63] constant array and the H0 constants;
  - the functions Ch, Maj, Σ0, Σ1, σ0, σ1;
  - a typedef for the working-state struct (a..h);
  - a typedef for the 16×32-bit schedule window.
- One sub-module, sha256_round:
  - combinational single round plus schedule update;
  - parameterized by round index;
  - instantiated 64× via generate, with pipeline registers in the top.
- Leading-zero counter: a function in the package.

Test Plan:
- Stream "A","B",...,"Z" on consecutive cycles. Each block is 0x<ascii>80 followed by zeros, with a low byte of 0x08; num_zero_i=3. Required response:
  - "A" → d_o 559aead08264d5795d3909718cdd05abd49572e84fe55590eef31a88a08fdffd, matched_o=0.
  - "B" → d_o df7e70e5021544f4834bbee64a9e3789febc4be81470df629cad6ddb03320a5c, matched_o=0.
  - "M" → d_o 08f271887ce94707da822d5263bae19d5519cb3614e0daedc4c7ce5dab7473f1, matched_o=1 (4 leading zeros).
  - "Z" → d_o bbeebd879e1dff6918546dc0c179fdde505f2a21591c9a9c96e36b054ec5af83.
  - All results on consecutive cycles 65 edges after input.
- Latency check: a single "abc" padded block → d_o ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad exactly 65 edges later; original_o equals the input block.
- Threshold boundaries on block "M":
  - num_zero_i=0 → matched_o=1.
  - num_zero_i=4 → matched_o=1.
  - num_zero_i=5 → matched_o=0.
  - num_zero_i=255 → matched_o=0.
- Per-block threshold: alternate num_zero_i 4/5 on back-to-back "M" blocks → matched_o alternates 1/0.
- Reset: assert reset low mid-stream → all outputs 0 immediately (asynchronously); after release, outputs stay 0 until the first post-reset block emerges 65 edges later.
- After reset with an idle pipeline → matched_o stays 0 and d_o stays 0, with no spurious match even though num_zero_i=0.
